dma_channel_arb: RTL and testbench
==================================

# dma_channel_arb

Parametrised successor to the single-stream host DMA hookup. It multiplexes NUM_CH client channels (CPU memory controller, SHA accelerators, nonce dumpers) onto the one host DMA read port and one host DMA write port. Read and write sides run independently, each with its own round-robin arbiter, owner register, beat counter and done tracking. It sits between the miner top level and the AFU's dma_if.

## Interface
Parameters:
- NUM_CH, 4: client channels, 2..8
- ADDR_WIDTH, 64: virtual byte address width
- SIZE_WIDTH, 59: transfer size in cache lines (CL address width + 1)
- DATA_WIDTH, 512: cache-line width

Ports (clock and reset first):
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CH  client transfer request
- req_wr  in  NUM_CH  direction per client: 1 = host write, 0 = host read
- req_addr  in  NUM_CH×ADDR_WIDTH  starting virtual byte address
- req_size  in  NUM_CH×SIZE_WIDTH  cache lines to move
- req_ready  out  NUM_CH  request accepted this cycle
- cl_rd_data  out  DATA_WIDTH  read data, broadcast to all clients
- cl_rd_valid  out  NUM_CH  read beat valid for the owning client
- cl_rd_ready  in  NUM_CH  client accepts the read beat
- cl_wr_data  in  NUM_CH×DATA_WIDTH  write data per client
- cl_wr_valid  in  NUM_CH  client has a write beat
- cl_wr_ready  out  NUM_CH  write beat taken
- cl_done  out  NUM_CH  one-cycle pulse when the client's transfer completes
- dma_rd_go, dma_rd_addr, dma_rd_size, dma_rd_en  out  1/ADDR/SIZE/1  host read channel
- dma_rd_data, dma_empty, dma_rd_done  in  DATA/1/1
- dma_wr_go, dma_wr_addr, dma_wr_size, dma_wr_en, dma_wr_data  out  1/ADDR/SIZE/1/DATA  host write channel
- dma_full, dma_wr_done  in  1/1
- rd_busy, wr_busy  out  1  direction not IDLE

## Operation
- Per direction, FSM states: IDLE, GO, XFER, WAIT_DONE.
- IDLE: the arbiter considers clients with req_valid & (req_wr == dir).
  - Grant is round-robin starting one past the last owner; after reset the last owner is NUM_CH-1, so client 0 has first priority.
  - req_ready[g] asserts combinationally. On that cycle addr, size and owner are registered.
- size == 0: the request is accepted and no go is issued. cl_done[g] pulses the next cycle. The FSM stays in IDLE.
- GO: dma_*_go = 1 for exactly one cycle, with addr and size stable from GO until return to IDLE. The stale dma_*_done level is ignored in this cycle. Next state is XFER.
- XFER, read side:
  - dma_rd_en = ~dma_empty & cl_rd_ready[owner].
  - cl_rd_valid[owner] = ~dma_empty. All other bits are 0.
  - Each rd_en decrements the remaining count. At count 0 the FSM goes to WAIT_DONE.
- XFER, write side:
  - dma_wr_en = cl_wr_valid[owner] & ~dma_full.
  - cl_wr_ready[owner] = ~dma_full. dma_wr_data = cl_wr_data[owner].
  - Each wr_en decrements the remaining count. At count 0 the FSM goes to WAIT_DONE.
- WAIT_DONE: on dma_*_done = 1, pulse cl_done[owner], update the last owner, go to IDLE.
- A client requesting both directions at once is served by both sides concurrently.
- Non-owner clients never see ready or valid.
- Outputs to non-owners, and all DMA strobes outside XFER, are 0.

## Timing
- Reset values: every output 0, FSMs IDLE, counters 0, last owner NUM_CH-1.
- Reset is asynchronous and takes effect mid-transfer. No done pulse is issued and the DMA is simply re-armed by the next go.
- Latency:
  - Request accept to go: 1 cycle.
  - Last beat to done: max(1, cycles until dma_*_done) + 1 cycle, giving a registered cl_done.
- Read data path is combinational (zero added latency). Write path is combinational.
- Counter: SIZE_WIDTH bits, loaded with req_size, decremented only on an enable. It never underflows because the enable is gated by count != 0.
- A new grant on the same direction is possible in the cycle after the done pulse (IDLE).

## Structure
- Package dma_arb_pkg holds:
  - typedef dma_state_t, an enum of the four states
  - typedef dir_t with DIR_RD / DIR_WR
  - function onehot_to_idx
- Sub-module rr_arbiter, parameter N: inputs req[N], advance, last_idx; outputs grant one-hot and grant_idx. It is instantiated once per direction.
- Read and write engines are two instances of the same always_ff/always_comb block pattern within the top level.

## Test plan
- Single read, client 1, addr 0x1000, size 4, dma_empty toggling every other cycle → one dma_rd_go with addr 0x1000 and size 4; exactly 4 rd_en; cl_done[1] 1 cycle after dma_rd_done.
- Clients 0, 2, 3 all requesting reads of size 2 → grant order 0, 2, 3; the next request from 0 is granted only after 3.
- Concurrent client 0 read (size 3) and client 2 write (size 3) with dma_full pulsed for 2 cycles → both complete; 3 wr_en, none during full; wr_data equals client 2's data.
- size 0 request from client 3 → req_ready[3], no go, cl_done[3] next cycle.
- rst_n low during XFER after 2 of 5 beats → all outputs 0 immediately; after release, a new size-1 request completes normally.
- Stale dma_rd_done held high from the previous transfer → GO cycle ignores it and cl_done waits for the full beat count.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
// Covers FSM states, transfer direction and one-hot decode.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GO,
        S_XFER,
        S_WAIT_DONE
    } dma_state_t;

    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_t;

    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_channel_arb_rr_arbiter.sv
// Round-robin arbiter: the search starts one past last_idx.
// Grants are only produced while advance is high.
module rr_arbiter
    import dma_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] j;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        j = '0;
        if (advance) begin
            for (int k = N; k >= 1; k--) begin
                j = IW'((int'(last_idx) + k) % N);
                if (req[j]) begin
                    grant = '0;
                    grant[j] = 1'b1;
                end
            end
        end
        grant_idx = IW'(onehot_to_idx(8'(grant)));
    end

endmodule

// File: rtl/dma_channel_arb.sv
// Multiplexes NUM_CH client channels onto one host DMA read port
// and one host DMA write port, each side arbitrated independently.
module dma_channel_arb
    import dma_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 59,
    parameter int DATA_WIDTH = 512
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH-1:0]            req_wr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*SIZE_WIDTH-1:0] req_size,
    output logic [NUM_CH-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]        cl_rd_data,
    output logic [NUM_CH-1:0]            cl_rd_valid,
    input  logic [NUM_CH-1:0]            cl_rd_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] cl_wr_data,
    input  logic [NUM_CH-1:0]            cl_wr_valid,
    output logic [NUM_CH-1:0]            cl_wr_ready,
    output logic [NUM_CH-1:0]            cl_done,
    output logic                         dma_rd_go,
    output logic [ADDR_WIDTH-1:0]        dma_rd_addr,
    output logic [SIZE_WIDTH-1:0]        dma_rd_size,
    output logic                         dma_rd_en,
    input  logic [DATA_WIDTH-1:0]        dma_rd_data,
    input  logic                         dma_empty,
    input  logic                         dma_rd_done,
    output logic                         dma_wr_go,
    output logic [ADDR_WIDTH-1:0]        dma_wr_addr,
    output logic [SIZE_WIDTH-1:0]        dma_wr_size,
    output logic                         dma_wr_en,
    output logic [DATA_WIDTH-1:0]        dma_wr_data,
    input  logic                         dma_full,
    input  logic                         dma_wr_done,
    output logic                         rd_busy,
    output logic                         wr_busy
);

    localparam int IW = $clog2(NUM_CH);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_CH - 1);

    dma_state_t rd_state_q, rd_state_d, wr_state_q, wr_state_d;
    logic [IW-1:0] rd_own_q, rd_own_d, wr_own_q, wr_own_d;
    logic [IW-1:0] rd_last_q, rd_last_d, wr_last_q, wr_last_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [SIZE_WIDTH-1:0] rd_size_q, rd_size_d, wr_size_q, wr_size_d;
    logic [SIZE_WIDTH-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [NUM_CH-1:0] rd_done_q, rd_done_d, wr_done_q, wr_done_d;
    logic [NUM_CH-1:0] rd_cand, wr_cand, rd_grant, wr_grant;
    logic [IW-1:0] rd_gidx, wr_gidx;
    logic [SIZE_WIDTH-1:0] rd_req_size, wr_req_size;

    always_comb begin
        rd_cand = '0;
        wr_cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_cand[i] = req_valid[i] & (dir_t'(req_wr[i]) == DIR_RD);
            wr_cand[i] = req_valid[i] & (dir_t'(req_wr[i]) == DIR_WR);
        end
    end

    rr_arbiter #(.N(NUM_CH)) u_rd_arb (
        .req(rd_cand), .advance(rd_state_q == S_IDLE),
        .last_idx(rd_last_q), .grant(rd_grant), .grant_idx(rd_gidx)
    );

    rr_arbiter #(.N(NUM_CH)) u_wr_arb (
        .req(wr_cand), .advance(wr_state_q == S_IDLE),
        .last_idx(wr_last_q), .grant(wr_grant), .grant_idx(wr_gidx)
    );

    assign rd_req_size = req_size[rd_gidx*SIZE_WIDTH +: SIZE_WIDTH];
    assign wr_req_size = req_size[wr_gidx*SIZE_WIDTH +: SIZE_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= S_IDLE;
            wr_state_q <= S_IDLE;
            rd_own_q   <= '0;
            wr_own_q   <= '0;
            rd_last_q  <= LAST_RST;
            wr_last_q  <= LAST_RST;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            rd_size_q  <= '0;
            wr_size_q  <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            rd_done_q  <= '0;
            wr_done_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_own_q   <= rd_own_d;
            wr_own_q   <= wr_own_d;
            rd_last_q  <= rd_last_d;
            wr_last_q  <= wr_last_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            rd_size_q  <= rd_size_d;
            wr_size_q  <= wr_size_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
        end
    end

    // Read engine: next state and registered bookkeeping.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_own_d   = rd_own_q;
        rd_last_d  = rd_last_q;
        rd_addr_d  = rd_addr_q;
        rd_size_d  = rd_size_q;
        rd_cnt_d   = rd_cnt_q;
        rd_done_d  = '0;
        unique case (rd_state_q)
            S_IDLE: if (|rd_grant) begin
                rd_own_d  = rd_gidx;
                rd_addr_d = req_addr[rd_gidx*ADDR_WIDTH +: ADDR_WIDTH];
                rd_size_d = rd_req_size;
                rd_cnt_d  = rd_req_size;
                if (rd_req_size == '0) begin
                    rd_done_d[rd_gidx] = 1'b1;
                    rd_last_d = rd_gidx;
                end else begin
                    rd_state_d = S_GO;
                end
            end
            S_GO: rd_state_d = S_XFER;
            S_XFER: if (dma_rd_en) begin
                rd_cnt_d = rd_cnt_q - 1'b1;
                if (rd_cnt_q == SIZE_WIDTH'(1)) rd_state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (dma_rd_done) begin
                rd_done_d[rd_own_q] = 1'b1;
                rd_last_d  = rd_own_q;
                rd_state_d = S_IDLE;
            end
            default: rd_state_d = S_IDLE;
        endcase
    end

    // Write engine: same pattern as the read side.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_own_d   = wr_own_q;
        wr_last_d  = wr_last_q;
        wr_addr_d  = wr_addr_q;
        wr_size_d  = wr_size_q;
        wr_cnt_d   = wr_cnt_q;
        wr_done_d  = '0;
        unique case (wr_state_q)
            S_IDLE: if (|wr_grant) begin
                wr_own_d  = wr_gidx;
                wr_addr_d = req_addr[wr_gidx*ADDR_WIDTH +: ADDR_WIDTH];
                wr_size_d = wr_req_size;
                wr_cnt_d  = wr_req_size;
                if (wr_req_size == '0) begin
                    wr_done_d[wr_gidx] = 1'b1;
                    wr_last_d = wr_gidx;
                end else begin
                    wr_state_d = S_GO;
                end
            end
            S_GO: wr_state_d = S_XFER;
            S_XFER: if (dma_wr_en) begin
                wr_cnt_d = wr_cnt_q - 1'b1;
                if (wr_cnt_q == SIZE_WIDTH'(1)) wr_state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (dma_wr_done) begin
                wr_done_d[wr_own_q] = 1'b1;
                wr_last_d  = wr_own_q;
                wr_state_d = S_IDLE;
            end
            default: wr_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dma_rd_en   = 1'b0;
        cl_rd_valid = '0;
        if (rd_state_q == S_XFER && rd_cnt_q != '0) begin
            cl_rd_valid[rd_own_q] = ~dma_empty;
            dma_rd_en = ~dma_empty & cl_rd_ready[rd_own_q];
        end
    end

    always_comb begin
        dma_wr_en   = 1'b0;
        cl_wr_ready = '0;
        dma_wr_data = '0;
        if (wr_state_q == S_XFER && wr_cnt_q != '0) begin
            cl_wr_ready[wr_own_q] = ~dma_full;
            dma_wr_en   = cl_wr_valid[wr_own_q] & ~dma_full;
            dma_wr_data = cl_wr_data[wr_own_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign req_ready   = rd_grant | wr_grant;
    assign cl_done     = rd_done_q | wr_done_q;
    assign cl_rd_data  = dma_rd_data;
    assign dma_rd_go   = rd_state_q == S_GO;
    assign dma_wr_go   = wr_state_q == S_GO;
    assign dma_rd_addr = rd_addr_q;
    assign dma_wr_addr = wr_addr_q;
    assign dma_rd_size = rd_size_q;
    assign dma_wr_size = wr_size_q;
    assign rd_busy     = rd_state_q != S_IDLE;
    assign wr_busy     = wr_state_q != S_IDLE;

endmodule

// File: tb/tb_dma_channel_arb.sv
// Directed bench for dma_channel_arb with hand-computed expectations.
module tb_dma_channel_arb;

    localparam int NC = 4;
    localparam int AW = 64;
    localparam int SW = 59;
    localparam int DW = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NC-1:0] req_valid, req_wr, req_ready;
    logic [NC*AW-1:0] req_addr;
    logic [NC*SW-1:0] req_size;
    logic [DW-1:0] cl_rd_data;
    logic [NC-1:0] cl_rd_valid, cl_rd_ready;
    logic [NC*DW-1:0] cl_wr_data;
    logic [NC-1:0] cl_wr_valid, cl_wr_ready, cl_done;
    logic dma_rd_go, dma_rd_en, dma_empty, dma_rd_done;
    logic [AW-1:0] dma_rd_addr, dma_wr_addr;
    logic [SW-1:0] dma_rd_size, dma_wr_size;
    logic [DW-1:0] dma_rd_data, dma_wr_data;
    logic dma_wr_go, dma_wr_en, dma_full, dma_wr_done;
    logic rd_busy, wr_busy;

    always #5 clk = ~clk;

    dma_channel_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size),
        .req_ready(req_ready),
        .cl_rd_data(cl_rd_data), .cl_rd_valid(cl_rd_valid),
        .cl_rd_ready(cl_rd_ready),
        .cl_wr_data(cl_wr_data), .cl_wr_valid(cl_wr_valid),
        .cl_wr_ready(cl_wr_ready), .cl_done(cl_done),
        .dma_rd_go(dma_rd_go), .dma_rd_addr(dma_rd_addr),
        .dma_rd_size(dma_rd_size), .dma_rd_en(dma_rd_en),
        .dma_rd_data(dma_rd_data), .dma_empty(dma_empty),
        .dma_rd_done(dma_rd_done),
        .dma_wr_go(dma_wr_go), .dma_wr_addr(dma_wr_addr),
        .dma_wr_size(dma_wr_size), .dma_wr_en(dma_wr_en),
        .dma_wr_data(dma_wr_data), .dma_full(dma_full),
        .dma_wr_done(dma_wr_done),
        .rd_busy(rd_busy), .wr_busy(wr_busy)
    );

    int ncmp = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monotonic event counters sampled mid-cycle; tests use deltas.
    int rd_go_cnt = 0, wr_go_cnt = 0, rd_en_cnt = 0, wr_en_cnt = 0;
    int full_viol = 0, data_bad = 0, own_bad = 0;
    int done_cnt [NC];
    logic [AW-1:0] go_addr = '0;
    logic [SW-1:0] go_size = '0;
    logic [NC-1:0] rd_mask = '1, wr_mask = '1;
    logic [DW-1:0] exp_wr_data = '0;

    initial for (int i = 0; i < NC; i++) done_cnt[i] = 0;

    always @(negedge clk) begin
        if (dma_rd_go) begin
            rd_go_cnt++;
            go_addr = dma_rd_addr;
            go_size = dma_rd_size;
        end
        if (dma_wr_go) wr_go_cnt++;
        if (dma_rd_en) rd_en_cnt++;
        if (dma_wr_en) begin
            wr_en_cnt++;
            if (dma_full) full_viol++;
            if (dma_wr_data !== exp_wr_data) data_bad++;
        end
        if (|(cl_rd_valid & ~rd_mask)) own_bad++;
        if (|(cl_wr_ready & ~wr_mask)) own_bad++;
        for (int i = 0; i < NC; i++) if (cl_done[i]) done_cnt[i]++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_wr = '0; req_addr = '0; req_size = '0;
        cl_rd_ready = '0; cl_wr_data = '0; cl_wr_valid = '0;
        dma_rd_data = '0; dma_empty = 1'b1; dma_rd_done = 1'b0;
        dma_full = 1'b0; dma_wr_done = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic set_req(input int c, input logic wr,
                           input logic [AW-1:0] a, input logic [SW-1:0] s);
        req_valid[c] = 1'b1;
        req_wr[c] = wr;
        req_addr[c*AW +: AW] = a;
        req_size[c*SW +: SW] = s;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60 && (rd_busy || wr_busy); i++) step();
        check(tag, {62'd0, rd_busy, wr_busy}, 64'd0);
    endtask

    int b_go, b_en, b_wen, b_fv, b_db, b_ob, b_d0, b_d1, b_d2, b_d3;
    int gcount;
    int order [4];
    logic [NC-1:0] granted;

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_done", 64'(cl_done), 64'd0);
        check("rst_busy", {62'd0, rd_busy, wr_busy}, 64'd0);
        check("rst_strobes",
              {60'd0, dma_rd_go, dma_rd_en, dma_wr_go, dma_wr_en}, 64'd0);
        check("rst_addr", dma_rd_addr, 64'd0);

        // Single read, client 1, size 4, empty toggling.
        step();
        rd_mask = 4'b0010; wr_mask = 4'b0000;
        cl_rd_ready = 4'b0010; dma_empty = 1'b1;
        b_go = rd_go_cnt; b_en = rd_en_cnt; b_d1 = done_cnt[1]; b_ob = own_bad;
        set_req(1, 1'b0, 64'h1000, 59'd4);
        @(negedge clk);
        check("t1_ready", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t1_go", 64'(dma_rd_go), 64'd1);
        check("t1_go_addr", dma_rd_addr, 64'h1000);
        check("t1_go_size", 64'(dma_rd_size), 64'd4);
        for (int i = 0; i < 40 && (rd_en_cnt - b_en) < 4; i++) begin
            step();
            dma_empty = ~dma_empty;
            @(negedge clk);
        end
        repeat (4) begin
            step();
            dma_empty = ~dma_empty;
        end
        check("t1_en_cnt", 64'(rd_en_cnt - b_en), 64'd4);
        check("t1_go_cnt", 64'(rd_go_cnt - b_go), 64'd1);
        check("t1_busy_wait", 64'(rd_busy), 64'd1);
        check("t1_no_early_done", 64'(done_cnt[1] - b_d1), 64'd0);
        dma_rd_done = 1'b1;
        @(negedge clk);
        check("t1_done_lat0", 64'(cl_done), 64'd0);
        step();
        dma_rd_done = 1'b0;
        @(negedge clk);
        check("t1_done_lat1", 64'(cl_done), 64'b0010);
        @(negedge clk);
        check("t1_done_pulse", 64'(cl_done), 64'd0);
        check("t1_own", 64'(own_bad - b_ob), 64'd0);

        // Round-robin among read clients 0, 2, 3 with 0 re-requesting.
        do_reset();
        rd_mask = '1;
        cl_rd_ready = '1; dma_empty = 1'b0; dma_rd_done = 1'b1;
        set_req(0, 1'b0, 64'h100, 59'd2);
        set_req(2, 1'b0, 64'h200, 59'd2);
        set_req(3, 1'b0, 64'h300, 59'd2);
        gcount = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int cyc = 0; cyc < 80 && gcount < 4; cyc++) begin
            @(negedge clk);
            granted = req_ready;
            if (|granted) begin
                for (int c = 0; c < NC; c++) if (granted[c]) order[gcount] = c;
                gcount++;
            end
            step();
            if (|granted && gcount != 1) req_valid = req_valid & ~granted;
        end
        req_valid = '0;
        check("t2_grants", 64'(gcount), 64'd4);
        check("t2_order0", 64'(order[0]), 64'd0);
        check("t2_order1", 64'(order[1]), 64'd2);
        check("t2_order2", 64'(order[2]), 64'd3);
        check("t2_order3", 64'(order[3]), 64'd0);
        wait_idle("t2_idle");
        step();
        dma_rd_done = 1'b0;

        // Concurrent read (client 0) and write (client 2).
        step();
        rd_mask = 4'b0001; wr_mask = 4'b0100;
        exp_wr_data = {16{32'hC0DE_0002}};
        cl_wr_data[0*DW +: DW] = {16{32'hBAD0_0000}};
        cl_wr_data[2*DW +: DW] = exp_wr_data;
        cl_wr_valid = 4'b0101; cl_rd_ready = 4'b0001;
        dma_empty = 1'b0; dma_rd_done = 1'b1; dma_wr_done = 1'b1;
        b_en = rd_en_cnt; b_wen = wr_en_cnt; b_fv = full_viol;
        b_db = data_bad; b_ob = own_bad;
        b_d0 = done_cnt[0]; b_d2 = done_cnt[2];
        set_req(0, 1'b0, 64'h4000, 59'd3);
        set_req(2, 1'b1, 64'h5000, 59'd3);
        @(negedge clk);
        check("t3_ready", 64'(req_ready), 64'b0101);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t3_go", {62'd0, dma_rd_go, dma_wr_go}, 64'b11);
        check("t3_wr_addr", dma_wr_addr, 64'h5000);
        step();
        dma_full = 1'b1;
        @(negedge clk);
        check("t3_full_ready", 64'(cl_wr_ready), 64'd0);
        step();
        step();
        dma_full = 1'b0;
        wait_idle("t3_idle");
        step();
        check("t3_rd_en", 64'(rd_en_cnt - b_en), 64'd3);
        check("t3_wr_en", 64'(wr_en_cnt - b_wen), 64'd3);
        check("t3_full_viol", 64'(full_viol - b_fv), 64'd0);
        check("t3_wr_data", 64'(data_bad - b_db), 64'd0);
        check("t3_own", 64'(own_bad - b_ob), 64'd0);
        check("t3_done0", 64'(done_cnt[0] - b_d0), 64'd1);
        check("t3_done2", 64'(done_cnt[2] - b_d2), 64'd1);
        dma_rd_done = 1'b0; dma_wr_done = 1'b0; cl_wr_valid = '0;

        // Zero-size request from client 3.
        step();
        b_go = rd_go_cnt;
        set_req(3, 1'b0, 64'h6000, 59'd0);
        @(negedge clk);
        check("t4_ready", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t4_done", 64'(cl_done), 64'b1000);
        check("t4_busy", 64'(rd_busy), 64'd0);
        @(negedge clk);
        check("t4_done_pulse", 64'(cl_done), 64'd0);
        check("t4_no_go", 64'(rd_go_cnt - b_go), 64'd0);

        // Reset during XFER after 2 of 5 beats.
        step();
        rd_mask = 4'b0010; cl_rd_ready = 4'b0010;
        dma_empty = 1'b0; dma_rd_done = 1'b0;
        b_en = rd_en_cnt;
        set_req(1, 1'b0, 64'h7000, 59'd5);
        step();
        req_valid = '0;
        for (int i = 0; i < 20 && (rd_en_cnt - b_en) < 2; i++) @(negedge clk);
        step();
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 64'(rd_busy), 64'd0);
        check("t5_rst_en", 64'(dma_rd_en), 64'd0);
        check("t5_rst_valid", 64'(cl_rd_valid), 64'd0);
        check("t5_rst_addr", dma_rd_addr, 64'd0);
        check("t5_rst_size", 64'(dma_rd_size), 64'd0);
        b_d1 = done_cnt[1];
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check("t5_no_done", 64'(done_cnt[1] - b_d1), 64'd0);
        b_go = rd_go_cnt; b_en = rd_en_cnt;
        set_req(1, 1'b0, 64'h2000, 59'd1);
        step();
        req_valid = '0;
        step();
        dma_rd_done = 1'b1;
        for (int i = 0; i < 20 && done_cnt[1] == b_d1; i++) @(negedge clk);
        check("t5_done", 64'(done_cnt[1] - b_d1), 64'd1);
        check("t5_go", 64'(rd_go_cnt - b_go), 64'd1);
        check("t5_go_addr", go_addr, 64'h2000);
        check("t5_en", 64'(rd_en_cnt - b_en), 64'd1);
        step();
        dma_rd_done = 1'b0;
        wait_idle("t5_idle");

        // Stale done level held high across a new transfer.
        step();
        rd_mask = 4'b0100; cl_rd_ready = 4'b0100;
        dma_empty = 1'b0; dma_rd_done = 1'b1;
        b_en = rd_en_cnt;
        set_req(2, 1'b0, 64'h3000, 59'd3);
        @(negedge clk);
        check("t6_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t6_go", 64'(dma_rd_go), 64'd1);
        check("t6_go_size", 64'(dma_rd_size), 64'd3);
        check("t6_go_done", 64'(cl_done), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("t6_done_c%0d", i), 64'(cl_done),
                  (i == 5) ? 64'b0100 : 64'd0);
            check($sformatf("t6_en_c%0d", i), 64'(dma_rd_en),
                  (i <= 3) ? 64'd1 : 64'd0);
        end
        check("t6_en_cnt", 64'(rd_en_cnt - b_en), 64'd3);
        dma_rd_done = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
